count_sequencer: RTL and testbench

Run controller for the team's 4-bit up-counter datapath. It accepts a start request carrying a target value and clears the counter. It then enables counting until the target is reached, flags completion, and either returns to idle or auto-reloads for periodic operation. It sits between a requesting control block and the counter, and owns the counter's clear and enable sequencing.

---
 rtl/count_sequencer_pkg.sv | 13 +
 rtl/count_sequencer_if.sv | 28 ++
 rtl/count_core.sv | 25 ++
 rtl/count_sequencer.sv | 98 +++++++++
 tb/tb_count_sequencer.sv | 193 +++++++++++++++++++
 5 files changed

// File: rtl/count_sequencer_pkg.sv
// rtl/count_sequencer_pkg.sv - shared state encoding and default width for the count sequencer
package count_sequencer_pkg;

  localparam int WIDTH_DEF = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/count_sequencer_if.sv
// rtl/count_sequencer_if.sv - request/status bundle between a control block and the sequencer
interface count_sequencer_if
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
);

  logic             start;
  logic [WIDTH-1:0] target;
  logic             reload;
  logic             abort;
  logic [WIDTH-1:0] count;
  logic             busy;
  logic             done;

  // Requesting control block
  modport master (
    output start, target, reload, abort,
    input  count, busy, done
  );

  // Sequencer side
  modport slave (
    input  start, target, reload, abort,
    output count, busy, done
  );

endinterface

// File: rtl/count_core.sv
// rtl/count_core.sv - WIDTH-bit up-counter with synchronous clear and count enable
module count_core
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             enable,
  output logic [WIDTH-1:0] count
);

  // Clear has priority over enable; the sequencer never enables past its target
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/count_sequencer.sv
// rtl/count_sequencer.sv - run controller sequencing clear/enable of the up-counter to a latched target
module count_sequencer
  import count_sequencer_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic              clock,
  input  logic              reset,
  count_sequencer_if.slave  bus
);

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] tgt_q;
  logic             rel_q;
  logic [WIDTH-1:0] count;
  logic             at_target;
  logic             clear;
  logic             enable;

  assign at_target = (count == tgt_q);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Run parameters captured on an accepted start; abort cancels any pending reload
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tgt_q <= '0;
      rel_q <= 1'b0;
    end else if (state_q == IDLE) begin
      if (bus.start) begin
        tgt_q <= bus.target;
        rel_q <= bus.reload;
      end
    end else if (bus.abort) begin
      rel_q <= 1'b0;
    end
  end

  // Next state and counter controls; abort outranks every other transition and freezes the count
  always_comb begin
    state_d = state_q;
    clear   = 1'b0;
    enable  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) state_d = CLEAR;
      end
      CLEAR: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else begin
          clear   = 1'b1;
          state_d = RUN;
        end
      end
      RUN: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (at_target) begin
          state_d = DONE;
        end else begin
          enable = 1'b1;
        end
      end
      DONE: begin
        if (bus.abort) begin
          state_d = IDLE;
        end else if (rel_q) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  count_core #(.WIDTH(WIDTH)) u_core (
    .clock  (clock),
    .reset  (reset),
    .clear  (clear),
    .enable (enable),
    .count  (count)
  );

  assign bus.count = count;
  assign bus.busy  = (state_q != IDLE);
  assign bus.done  = (state_q == DONE);

endmodule

// File: tb/tb_count_sequencer.sv
// tb/tb_count_sequencer.sv - self-checking bench for count_sequencer against a cycle-offset reference model
module tb_count_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;

  always #5 clock = ~clock;

  count_sequencer_if #(.WIDTH(4)) bus ();

  count_sequencer #(.WIDTH(4)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  int done_times[$];
  int start_cyc;
  int n_before;

  // Reference: a run is an offset k from the accepted start edge.
  // k=1..T+1 -> count=k-1, k=T+2 -> done, k=T+3 -> end of pass.
  int m_active;
  int m_k;
  int m_t;
  int m_rel;
  int m_count;

  function automatic void model_reset();
    m_active = 0;
    m_k      = 0;
    m_t      = 0;
    m_rel    = 0;
    m_count  = 0;
  endfunction

  function automatic void model_edge();
    if (reset) begin
      model_reset();
    end else if (m_active == 0) begin
      if (bus.start) begin
        m_active = 1;
        m_k      = 0;
        m_t      = int'(bus.target);
        m_rel    = bus.reload ? 1 : 0;
      end
    end else if (bus.abort) begin
      m_active = 0;
      m_rel    = 0;
    end else begin
      m_k = m_k + 1;
      if (m_k <= m_t + 1) m_count = m_k - 1;
      if (m_k == m_t + 3) begin
        if (m_rel != 0) m_k = 0;
        else m_active = 0;
      end
    end
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_outputs(input string tag);
    logic [31:0] exp_done;
    exp_done = (m_active != 0 && m_k == m_t + 2) ? 32'd1 : 32'd0;
    check({tag, ".count"}, 32'(bus.count), 32'(m_count));
    check({tag, ".busy"}, 32'(bus.busy), 32'(m_active));
    check({tag, ".done"}, 32'(bus.done), exp_done);
  endtask

  task automatic step(input string tag);
    @(posedge clock);
    model_edge();
    cyc++;
    #1;
    if (bus.done === 1'b1) done_times.push_back(cyc);
    check_outputs(tag);
  endtask

  task automatic set_in(input logic s, input logic [3:0] t, input logic r, input logic a);
    bus.start  = s;
    bus.target = t;
    bus.reload = r;
    bus.abort  = a;
  endtask

  initial begin
    model_reset();
    set_in(1'b0, 4'd0, 1'b0, 1'b0);

    // Reset state
    step("reset");
    reset = 1'b0;
    step("idle");

    // target=5, no reload: done exactly at E7
    done_times.delete();
    set_in(1'b1, 4'd5, 1'b0, 1'b0);
    start_cyc = cyc + 1;
    step("t5");
    set_in(1'b0, 4'd5, 1'b0, 1'b0);
    repeat (10) step("t5");
    check("t5.pulses", 32'(done_times.size()), 32'd1);
    if (done_times.size() > 0) check("t5.done_edge", 32'(done_times[0] - start_cyc), 32'd7);
    check("t5.hold", 32'(bus.count), 32'd5);

    // target=0
    set_in(1'b1, 4'd0, 1'b0, 1'b0);
    step("t0");
    set_in(1'b0, 4'd0, 1'b0, 1'b0);
    repeat (4) step("t0");

    // target=3 with reload: three passes, then abort
    done_times.delete();
    set_in(1'b1, 4'd3, 1'b1, 1'b0);
    step("rel");
    set_in(1'b0, 4'd3, 1'b0, 1'b0);
    repeat (20) step("rel");
    check("rel.pulses", 32'(done_times.size()), 32'd3);
    for (int i = 1; i < done_times.size(); i++)
      check("rel.period", 32'(done_times[i] - done_times[i-1]), 32'd6);
    n_before = done_times.size();
    set_in(1'b0, 4'd3, 1'b0, 1'b1);
    step("rel_abort");
    check("rel_abort.busy", 32'(bus.busy), 32'd0);
    set_in(1'b0, 4'd3, 1'b0, 1'b0);
    repeat (8) step("rel_after");
    check("rel_after.no_done", 32'(done_times.size()), 32'(n_before));

    // start while busy and mid-run target change are ignored
    set_in(1'b1, 4'd4, 1'b0, 1'b0);
    step("busy_start");
    set_in(1'b1, 4'd9, 1'b1, 1'b0);
    repeat (3) step("busy_start");
    set_in(1'b0, 4'd9, 1'b1, 1'b0);
    repeat (8) step("busy_start");
    check("busy_start.final", 32'(bus.count), 32'd4);

    // abort on the cycle count reaches target
    done_times.delete();
    set_in(1'b1, 4'd6, 1'b0, 1'b0);
    step("abort_tgt");
    set_in(1'b0, 4'd6, 1'b0, 1'b0);
    repeat (7) step("abort_tgt");
    check("abort_tgt.at_target", 32'(bus.count), 32'd6);
    set_in(1'b0, 4'd6, 1'b0, 1'b1);
    step("abort_tgt");
    set_in(1'b0, 4'd6, 1'b0, 1'b0);
    repeat (3) step("abort_tgt");
    check("abort_tgt.no_done", 32'(done_times.size()), 32'd0);

    // maximum target, no wrap
    set_in(1'b1, 4'd15, 1'b0, 1'b0);
    step("t15");
    set_in(1'b0, 4'd15, 1'b0, 1'b0);
    repeat (20) step("t15");
    check("t15.hold", 32'(bus.count), 32'd15);

    // asynchronous reset mid-RUN at count=2
    set_in(1'b1, 4'd9, 1'b0, 1'b0);
    step("areset");
    set_in(1'b0, 4'd9, 1'b0, 1'b0);
    repeat (3) step("areset");
    check("areset.pre", 32'(bus.count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs("areset.async");
    step("areset.held");
    reset = 1'b0;
    step("areset.idle");

    // randomized traffic
    repeat (400) begin
      set_in(($urandom_range(3) == 0), 4'($urandom_range(15)),
             ($urandom_range(3) == 0), ($urandom_range(15) == 0));
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
